// File: rtl/acc_responder_pkg.sv
// Shared types for the ACC reference accelerator: opcode encoding and default response entry.
package acc_responder_pkg;

  localparam int unsigned RSP_DATA_W = 32;
  localparam int unsigned RSP_ID_W   = 4;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_XOR  = 4'd2,
    OP_MAC  = 4'd3,
    OP_SWAP = 4'd4
  } op_e;

  typedef struct packed {
    logic [RSP_DATA_W-1:0] data0;
    logic [RSP_DATA_W-1:0] data1;
    logic                  dual_wb;
    logic                  error;
    logic [RSP_ID_W-1:0]   id;
  } rsp_entry_t;

  function automatic logic op_is_legal(input logic [3:0] op);
    return op <= 4'(OP_SWAP);
  endfunction

endpackage

// File: rtl/acc_responder_rsp_fifo.sv
// In-order response buffer: Depth entries (any Depth >= 1), outputs driven from stored state only.
module acc_responder_rsp_fifo
  import acc_responder_pkg::*;
#(
  parameter int unsigned Depth   = 4,
  parameter type         entry_t = rsp_entry_t
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         wr_en_i,
  input  entry_t                       wr_data_i,
  input  logic                         rd_en_i,
  output entry_t                       rd_data_o,
  output logic                         full_o,
  output logic                         empty_o,
  output logic [$clog2(Depth + 1)-1:0] usage_o
);
  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  entry_t          r_mem [Depth];
  logic [PtrW-1:0] r_wr_ptr;
  logic [PtrW-1:0] r_rd_ptr;
  logic [CntW-1:0] r_count;
  logic            w_push;
  logic            w_pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  assign empty_o = (r_count == '0);
  assign full_o  = (r_count == CntW'(Depth));
  assign usage_o = r_count;
  assign w_pop   = rd_en_i & ~empty_o;
  assign w_push  = wr_en_i & (~full_o | w_pop);

  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wr_ptr] <= wr_data_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      if (w_push && !w_pop)      r_count <= r_count + CntW'(1);
      else if (!w_push && w_pop) r_count <= r_count - CntW'(1);
    end
  end

  // Empty buffer presents an all-zero entry so idle outputs read as 0.
  assign rd_data_o = empty_o ? '0 : r_mem[r_rd_ptr];

endmodule

// File: rtl/acc_slv_responder.sv
// ACC-bus reference accelerator: op decode, Latency-stage pipeline, credit counter, in-order responses.
// Define ACC_SLV_RESPONDER_ERR_CHECK_EN to flag unknown opcodes instead of executing them as ADD.
module acc_slv_responder
  import acc_responder_pkg::*;
#(
  parameter int unsigned DataWidth = 32,
  parameter int unsigned AddrWidth = 4,
  parameter int unsigned IdWidth   = 4,
  parameter int unsigned Latency   = 2,
  parameter int unsigned RspDepth  = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [AddrWidth-1:0] q_addr_i,
  input  logic [IdWidth-1:0]   q_id_i,
  input  logic [31:0]          q_data_op_i,
  input  logic [DataWidth-1:0] q_data_arga_i,
  input  logic [DataWidth-1:0] q_data_argb_i,
  input  logic [DataWidth-1:0] q_data_argc_i,
  input  logic                 q_valid_i,
  output logic                 q_ready_o,
  output logic [DataWidth-1:0] p_data0_o,
  output logic [DataWidth-1:0] p_data1_o,
  output logic                 p_dual_writeback_o,
  output logic [IdWidth-1:0]   p_id_o,
  output logic                 p_error_o,
  output logic                 p_valid_o,
  input  logic                 p_ready_i
);
  localparam int unsigned CntW = $clog2(RspDepth + 1);

  typedef struct packed {
    logic [DataWidth-1:0] data0;
    logic [DataWidth-1:0] data1;
    logic                 dual_wb;
    logic                 error;
    logic [IdWidth-1:0]   id;
  } entry_t;

  entry_t               w_entry;
  entry_t               w_rsp;
  entry_t               r_stg_entry [Latency];
  logic                 r_stg_valid [Latency];
  logic [3:0]           w_op;
  logic [DataWidth-1:0] w_mac;
  logic                 w_accept;
  logic                 w_deliver;
  logic                 w_fifo_empty;
  logic                 w_fifo_full;
  logic [CntW-1:0]      w_fifo_usage;
  logic [CntW-1:0]      r_outstanding;
  logic [CntW-1:0]      w_outstanding_next;
  logic                 r_q_ready;
  logic                 w_unused;

  assign w_op      = q_data_op_i[3:0];
  assign w_mac     = q_data_arga_i * q_data_argb_i + q_data_argc_i;
  assign w_accept  = q_valid_i & r_q_ready;
  assign w_deliver = ~w_fifo_empty & p_ready_i;

  always_comb begin
    w_entry    = '0;
    w_entry.id = q_id_i;
    case (w_op)
      OP_ADD:  w_entry.data0 = q_data_arga_i + q_data_argb_i;
      OP_SUB:  w_entry.data0 = q_data_arga_i - q_data_argb_i;
      OP_XOR:  w_entry.data0 = q_data_arga_i ^ q_data_argb_i;
      OP_MAC:  w_entry.data0 = w_mac;
      OP_SWAP: begin
        w_entry.data0   = q_data_argb_i;
        w_entry.data1   = q_data_arga_i;
        w_entry.dual_wb = 1'b1;
      end
      default: begin
`ifdef ACC_SLV_RESPONDER_ERR_CHECK_EN
        w_entry.error = ~op_is_legal(w_op);
`else
        w_entry.data0 = q_data_arga_i + q_data_argb_i;
`endif
      end
    endcase
  end

  // The result is computed at acceptance and then only delayed, so every stage is a plain shift.
  generate
    for (genvar gi = 0; gi < Latency; gi++) begin : g_stage
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          r_stg_valid[gi] <= 1'b0;
          r_stg_entry[gi] <= '0;
        end else if (gi == 0) begin
          r_stg_valid[gi] <= w_accept;
          r_stg_entry[gi] <= w_entry;
        end else begin
          r_stg_valid[gi] <= r_stg_valid[(gi == 0) ? 0 : gi - 1];
          r_stg_entry[gi] <= r_stg_entry[(gi == 0) ? 0 : gi - 1];
        end
      end
    end
  endgenerate

  acc_responder_rsp_fifo #(
    .Depth   (RspDepth),
    .entry_t (entry_t)
  ) u_rsp_fifo (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .wr_en_i   (r_stg_valid[Latency-1]),
    .wr_data_i (r_stg_entry[Latency-1]),
    .rd_en_i   (w_deliver),
    .rd_data_o (w_rsp),
    .full_o    (w_fifo_full),
    .empty_o   (w_fifo_empty),
    .usage_o   (w_fifo_usage)
  );

  // Credits cover pipeline plus buffer, so the buffer can never be asked to overflow.
  always_comb begin
    w_outstanding_next = r_outstanding;
    if (w_accept && !w_deliver)      w_outstanding_next = r_outstanding + CntW'(1);
    else if (!w_accept && w_deliver) w_outstanding_next = r_outstanding - CntW'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_outstanding <= '0;
      r_q_ready     <= 1'b0;
    end else begin
      r_outstanding <= w_outstanding_next;
      r_q_ready     <= (w_outstanding_next < CntW'(RspDepth));
    end
  end

  assign q_ready_o          = r_q_ready;
  assign p_valid_o          = ~w_fifo_empty;
  assign p_data0_o          = w_rsp.data0;
  assign p_data1_o          = w_rsp.data1;
  assign p_dual_writeback_o = w_rsp.dual_wb;
  assign p_id_o             = w_rsp.id;

`ifdef ACC_SLV_RESPONDER_ERR_CHECK_EN
  assign p_error_o = w_rsp.error;
  assign w_unused  = ^{q_addr_i, q_data_op_i[31:4], w_fifo_full, w_fifo_usage};
`else
  assign p_error_o = 1'b0;
  assign w_unused  = ^{q_addr_i, q_data_op_i[31:4], w_fifo_full, w_fifo_usage, w_rsp.error};
`endif

endmodule

// File: tb/tb_acc_slv_responder.sv
// Self-checking bench for acc_slv_responder: directed cases plus randomized traffic vs a queue model.
module tb_acc_slv_responder;
  localparam int DW    = 32;
  localparam int AW    = 4;
  localparam int IW    = 4;
  localparam int LAT   = 2;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [AW-1:0] q_addr = '0;
  logic [IW-1:0] q_id = '0;
  logic [31:0]   q_op = '0;
  logic [DW-1:0] q_a = '0;
  logic [DW-1:0] q_b = '0;
  logic [DW-1:0] q_c = '0;
  logic          q_valid = 1'b0;
  logic          q_ready;
  logic [DW-1:0] p_d0;
  logic [DW-1:0] p_d1;
  logic          p_dual;
  logic [IW-1:0] p_id;
  logic          p_err;
  logic          p_valid;
  logic          p_ready = 1'b0;

  acc_slv_responder #(
    .DataWidth (DW), .AddrWidth (AW), .IdWidth (IW), .Latency (LAT), .RspDepth (DEPTH)
  ) dut (
    .clk_i              (clk),
    .rst_ni             (rst_n),
    .q_addr_i           (q_addr),
    .q_id_i             (q_id),
    .q_data_op_i        (q_op),
    .q_data_arga_i      (q_a),
    .q_data_argb_i      (q_b),
    .q_data_argc_i      (q_c),
    .q_valid_i          (q_valid),
    .q_ready_o          (q_ready),
    .p_data0_o          (p_d0),
    .p_data1_o          (p_d1),
    .p_dual_writeback_o (p_dual),
    .p_id_o             (p_id),
    .p_error_o          (p_err),
    .p_valid_o          (p_valid),
    .p_ready_i          (p_ready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int edges_since_rst = 0;
  int acc_count = 0;
  int dlv_count = 0;
  logic [IW-1:0] dlv_ids[$];

  typedef struct {
    logic [DW-1:0] d0;
    logic [DW-1:0] d1;
    logic          dual;
    logic          err;
    logic [IW-1:0] id;
    int            rdy;
  } exp_t;
  exp_t q_exp[$];

  always @(posedge clk) begin
    cyc++;
    if (rst_n) edges_since_rst++;
    else edges_since_rst = 0;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h cycle=%0d", name, act, req, cyc);
    end
  endtask

  // Response an ideal responder must give for one request.
  function automatic exp_t model(input logic [31:0] op, input logic [DW-1:0] a, b, c,
                                 input logic [IW-1:0] id);
    exp_t e;
    e.d0 = '0; e.d1 = '0; e.dual = 1'b0; e.err = 1'b0; e.id = id; e.rdy = 0;
    case (op[3:0])
      4'd0: e.d0 = a + b;
      4'd1: e.d0 = a - b;
      4'd2: e.d0 = a ^ b;
      4'd3: e.d0 = DW'(a * b + c);
      4'd4: begin e.d0 = b; e.d1 = a; e.dual = 1'b1; end
      default: begin
`ifdef ACC_SLV_RESPONDER_ERR_CHECK_EN
        e.err = 1'b1;
`else
        e.d0 = a + b;
`endif
      end
    endcase
    return e;
  endfunction

  // Per-cycle comparison against the model, then predict what the coming edge transfers.
  always @(negedge clk) begin
    exp_t h;
    exp_t n;
    bit   exp_valid;
    if (!rst_n) begin
      q_exp.delete();
      chk("rst_q_ready", 32'(q_ready), 0);
      chk("rst_p_valid", 32'(p_valid), 0);
      chk("rst_p_data0", p_d0, 0);
      chk("rst_p_data1", p_d1, 0);
      chk("rst_p_misc", {25'd0, p_dual, p_err, 1'b0, p_id}, 0);
    end else begin
      exp_valid = (q_exp.size() > 0) && (q_exp[0].rdy <= cyc);
      chk("q_ready", 32'(q_ready), 32'((edges_since_rst > 0) && (q_exp.size() < DEPTH)));
      chk("p_valid", 32'(p_valid), 32'(exp_valid));
      if (exp_valid && p_valid) begin
        h = q_exp[0];
        chk("rsp_data0", p_d0, h.d0);
        chk("rsp_data1", p_d1, h.d1);
        chk("rsp_dual", 32'(p_dual), 32'(h.dual));
        chk("rsp_error", 32'(p_err), 32'(h.err));
        chk("rsp_id", 32'(p_id), 32'(h.id));
      end
      if (p_valid && p_ready) begin
        dlv_ids.push_back(p_id);
        dlv_count++;
      end
      if (exp_valid && p_ready) void'(q_exp.pop_front());
      if (q_valid && q_ready) begin
        n = model(q_op, q_a, q_b, q_c, q_id);
        n.rdy = cyc + 1 + LAT;
        q_exp.push_back(n);
        acc_count++;
      end
    end
  end

  // Called just after a posedge; returns just after the accepting posedge with its edge number.
  task automatic send(input logic [31:0] op, input logic [DW-1:0] a, b, c,
                      input logic [IW-1:0] id, output int acc_cyc);
    bit got;
    got = 1'b0;
    q_op = op; q_a = a; q_b = b; q_c = c; q_id = id;
    q_addr = AW'($urandom);
    q_valid = 1'b1;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (q_ready) begin got = 1'b1; break; end
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL send_timeout: actual=no_accept required=accept id=%0d", id);
    end
    @(posedge clk); #1;
    acc_cyc = cyc;
    q_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int rsp_cyc, output bit ok);
    ok = 1'b0;
    rsp_cyc = 0;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (p_valid) begin ok = 1'b1; rsp_cyc = cyc; break; end
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL rsp_timeout: actual=no_p_valid required=p_valid");
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: actual=still_running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    int   na, rc, seen, base, gap;
    bit   ok;
    bit   drv_done;
    logic [31:0] op;

    e = model(32'h1, 32'h0, 32'h1, 32'h0, 4'h0);
    chk("model_sub_wrap", e.d0, 32'hFFFF_FFFF);
    e = model(32'h3, 32'h10000, 32'h10000, 32'h3, 4'h0);
    chk("model_mac_wrap", e.d0, 32'h3);
    e = model(32'h4, 32'h1, 32'h2, 32'h0, 4'h0);
    chk("model_swap_d1", e.d1, 32'h1);

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rel_q_ready_first", 32'(q_ready), 0);
    @(posedge clk); #1;
    p_ready = 1'b1;

    send(32'h0, 32'd5, 32'd7, 32'd0, 4'd3, na);
    wait_rsp(rc, ok);
    if (ok) begin
      chk("add_latency", 32'(rc - na), 32'(LAT));
      chk("add_data0", p_d0, 32'd12);
      chk("add_id", 32'(p_id), 32'd3);
      chk("add_error", 32'(p_err), 32'd0);
    end
    @(posedge clk); #1;

    send(32'h1, 32'd0, 32'd1, 32'd0, 4'd1, na);
    wait_rsp(rc, ok);
    if (ok) chk("sub_wrap", p_d0, 32'hFFFF_FFFF);
    @(posedge clk); #1;
    send(32'h3, 32'h10000, 32'h10000, 32'd3, 4'd2, na);
    wait_rsp(rc, ok);
    if (ok) chk("mac_wrap", p_d0, 32'd3);
    @(posedge clk); #1;

    send(32'h4, 32'd1, 32'd2, 32'd0, 4'd5, na);
    wait_rsp(rc, ok);
    if (ok) begin
      chk("swap_data0", p_d0, 32'd2);
      chk("swap_data1", p_d1, 32'd1);
      chk("swap_dual", 32'(p_dual), 32'd1);
    end
    @(posedge clk); #1;

    send(32'hF, 32'd5, 32'd9, 32'd0, 4'd6, na);
    wait_rsp(rc, ok);
    if (ok) begin
`ifdef ACC_SLV_RESPONDER_ERR_CHECK_EN
      chk("badop_error", 32'(p_err), 32'd1);
      chk("badop_data0", p_d0, 32'd0);
`else
      chk("badop_error", 32'(p_err), 32'd0);
      chk("badop_data0", p_d0, 32'd14);
`endif
      chk("badop_id", 32'(p_id), 32'd6);
    end
    @(posedge clk); #1;

    // Backpressure: only RspDepth requests may be outstanding.
    p_ready = 1'b0;
    dlv_ids.delete();
    base = acc_count;
    fork
      begin
        for (int i = 0; i < 6; i++) send(32'h0, DW'(i), 32'd1, 32'd0, IW'(i), na);
      end
      begin
        repeat (20) @(posedge clk);
        @(negedge clk);
        chk("bp_accepted", 32'(acc_count - base), 32'd4);
        chk("bp_q_ready", 32'(q_ready), 32'd0);
        @(posedge clk); #1;
        p_ready = 1'b1;
      end
    join
    repeat (12) @(posedge clk);
    #1;
    chk("bp_total_accepted", 32'(acc_count - base), 32'd6);
    chk("bp_rsp_count", 32'(dlv_ids.size()), 32'd6);
    for (int i = 0; i < 4; i++)
      if (i < dlv_ids.size()) chk("bp_order_id", 32'(dlv_ids[i]), 32'(i));

    // Reset with three requests outstanding; none may surface afterwards.
    p_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(32'h2, DW'($urandom), DW'($urandom), 32'd0, IW'(8 + i), na);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_q_ready", 32'(q_ready), 32'd0);
    chk("midrst_p_valid", 32'(p_valid), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    p_ready = 1'b1;
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (p_valid) seen++;
    end
    chk("midrst_no_stale", 32'(seen), 32'd0);
    @(posedge clk); #1;

    // Randomized traffic with random response backpressure.
    base = dlv_count;
    drv_done = 1'b0;
    fork
      begin
        for (int k = 0; k < 1000; k++) begin
          op = $urandom;
          op[3:0] = ($urandom_range(0, 9) < 8) ? 4'($urandom_range(0, 4)) : 4'($urandom_range(5, 15));
          send(op, ($urandom_range(0, 3) == 0) ? DW'($urandom_range(0, 3)) : DW'($urandom),
               DW'($urandom), DW'($urandom), IW'($urandom), na);
          gap = $urandom_range(0, 2);
          repeat (gap) begin @(posedge clk); #1; end
        end
        drv_done = 1'b1;
      end
      begin
        while (!drv_done) begin
          p_ready = ($urandom_range(0, 3) != 0);
          @(posedge clk); #1;
        end
      end
    join
    p_ready = 1'b1;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (q_exp.size() == 0) break;
    end
    chk("drain_empty", 32'(q_exp.size()), 32'd0);
    chk("rand_rsp_count", 32'(dlv_count - base), 32'd1000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
